// File: rtl/hspi_receiver.sv
// Purpose : HSPI burst receiver. Grants a burst when the downstream FIFO has room,
//           forwards each valid word to the FIFO and flags short, stalled and stray traffic.
// Latency : 1 cycle from an accepted hrvld word to its fifo_write_en strobe.
// Backpr. : fifo_almost_full only gates the start of a burst; a running burst is
//           never stalled, so the FIFO must keep BURST_LEN+2 words of headroom.
// Ports   : sys_clk/sys_rst_n clock and async active-low reset;
//           hrreq/hrrdy/hrvld/hrd HSPI burst handshake and data;
//           hspi_cts, fifo_write_en, fifo_write_data, fifo_almost_full downstream FIFO side;
//           burst_count, err_short, err_timeout, err_overrun, busy status.
module hspi_receiver #(
  parameter int BURST_LEN = 256,
  parameter int TIMEOUT   = 1024
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        hrreq,
  output logic        hrrdy,
  input  logic        hrvld,
  input  logic [31:0] hrd,
  output logic        hspi_cts,
  output logic        fifo_write_en,
  output logic [31:0] fifo_write_data,
  input  logic        fifo_almost_full,
  output logic [15:0] burst_count,
  output logic        err_short,
  output logic        err_timeout,
  output logic        err_overrun,
  output logic        busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RECV = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Compare against the pre-increment value so the counters stay 16 bits wide.
  localparam logic [15:0] LAST_WORD = 16'(BURST_LEN - 1);
  localparam logic [15:0] LAST_IDLE = 16'(TIMEOUT - 1);

  logic [1:0]  state_q, state_d;
  logic [15:0] word_cnt_q, word_cnt_d;
  logic [15:0] idle_cnt_q, idle_cnt_d;
  logic        hrrdy_q, hrrdy_d;
  logic        busy_q, busy_d;
  logic        hspi_cts_q, hspi_cts_d;
  logic        wr_en_q, wr_en_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic [15:0] burst_cnt_q, burst_cnt_d;
  logic        err_short_q, err_short_d;
  logic        err_timeout_q, err_timeout_d;
  logic        err_overrun_q, err_overrun_d;

  always_comb begin
    state_d       = state_q;
    word_cnt_d    = word_cnt_q;
    idle_cnt_d    = idle_cnt_q;
    wr_en_d       = 1'b0;
    wr_data_d     = wr_data_q;
    burst_cnt_d   = burst_cnt_q;
    err_short_d   = err_short_q;
    err_timeout_d = err_timeout_q;
    err_overrun_d = err_overrun_q;
    hspi_cts_d    = ~fifo_almost_full;

    case (state_q)
      IDLE: begin
        if (hrvld) err_overrun_d = 1'b1;
        if (hrreq && !fifo_almost_full) begin
          state_d    = RECV;
          word_cnt_d = '0;
          idle_cnt_d = '0;
        end
      end
      RECV: begin
        if (hrvld) begin
          // The word is taken before any early-drop decision, so a word that
          // arrives together with the hrreq drop still reaches the FIFO.
          wr_en_d    = 1'b1;
          wr_data_d  = hrd;
          word_cnt_d = word_cnt_q + 16'd1;
          idle_cnt_d = '0;
          if (word_cnt_q == LAST_WORD) begin
            state_d     = DONE;
            burst_cnt_d = burst_cnt_q + 16'd1;
          end else if (!hrreq) begin
            state_d     = DONE;
            err_short_d = 1'b1;
          end
        end else begin
          idle_cnt_d = idle_cnt_q + 16'd1;
          if (!hrreq) begin
            state_d     = DONE;
            err_short_d = 1'b1;
          end else if (idle_cnt_q == LAST_IDLE) begin
            state_d       = DONE;
            err_timeout_d = 1'b1;
          end
        end
      end
      DONE: begin
        if (hrvld) err_overrun_d = 1'b1;
        if (!hrreq) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Registered from the next state so they track state_q exactly.
    hrrdy_d = (state_d == RECV);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q       <= IDLE;
      word_cnt_q    <= '0;
      idle_cnt_q    <= '0;
      hrrdy_q       <= 1'b0;
      busy_q        <= 1'b0;
      hspi_cts_q    <= 1'b0;
      wr_en_q       <= 1'b0;
      wr_data_q     <= '0;
      burst_cnt_q   <= '0;
      err_short_q   <= 1'b0;
      err_timeout_q <= 1'b0;
      err_overrun_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      word_cnt_q    <= word_cnt_d;
      idle_cnt_q    <= idle_cnt_d;
      hrrdy_q       <= hrrdy_d;
      busy_q        <= busy_d;
      hspi_cts_q    <= hspi_cts_d;
      wr_en_q       <= wr_en_d;
      wr_data_q     <= wr_data_d;
      burst_cnt_q   <= burst_cnt_d;
      err_short_q   <= err_short_d;
      err_timeout_q <= err_timeout_d;
      err_overrun_q <= err_overrun_d;
    end
  end

  assign hrrdy           = hrrdy_q;
  assign busy            = busy_q;
  assign hspi_cts        = hspi_cts_q;
  assign fifo_write_en   = wr_en_q;
  assign fifo_write_data = wr_data_q;
  assign burst_count     = burst_cnt_q;
  assign err_short       = err_short_q;
  assign err_timeout     = err_timeout_q;
  assign err_overrun     = err_overrun_q;

endmodule

// File: tb/tb_hspi_receiver.sv
// Purpose : self-checking bench for hspi_receiver with BURST_LEN=4, TIMEOUT=8.
// Latency : expects each FIFO write one edge after its accepted word.
// Backpr. : drives fifo_almost_full directly to exercise the burst-start gate.
module tb_hspi_receiver;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        hrreq = 1'b0;
  logic        hrrdy;
  logic        hrvld = 1'b0;
  logic [31:0] hrd = '0;
  logic        hspi_cts;
  logic        fifo_write_en;
  logic [31:0] fifo_write_data;
  logic        fifo_almost_full = 1'b0;
  logic [15:0] burst_count;
  logic        err_short;
  logic        err_timeout;
  logic        err_overrun;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int writes = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic        req;
    logic        vld;
    logic [31:0] d;
    logic        e_rdy;
    logic        e_busy;
    logic        e_wr;
  } vec_t;

  vec_t vecs[$];

  hspi_receiver #(.BURST_LEN(4), .TIMEOUT(8)) dut (
    .sys_clk         (sys_clk),
    .sys_rst_n       (sys_rst_n),
    .hrreq           (hrreq),
    .hrrdy           (hrrdy),
    .hrvld           (hrvld),
    .hrd             (hrd),
    .hspi_cts        (hspi_cts),
    .fifo_write_en   (fifo_write_en),
    .fifo_write_data (fifo_write_data),
    .fifo_almost_full(fifo_almost_full),
    .burst_count     (burst_count),
    .err_short       (err_short),
    .err_timeout     (err_timeout),
    .err_overrun     (err_overrun),
    .busy            (busy)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  // Scoreboard: every FIFO write must match the oldest word expected.
  always @(negedge sys_clk) begin
    if (fifo_write_en) begin
      writes++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write actual=%0h required=none", fifo_write_data);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (fifo_write_data !== e) begin
          errors++;
          $display("FAIL write_data actual=%0h required=%0h", fifo_write_data, e);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;

    // Nominal burst, back-to-back words.
    vecs.push_back('{1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 32'h11111111, 1'b1, 1'b1, 1'b1});
    vecs.push_back('{1'b1, 1'b1, 32'h22222222, 1'b1, 1'b1, 1'b1});
    vecs.push_back('{1'b1, 1'b1, 32'h33333333, 1'b1, 1'b1, 1'b1});
    vecs.push_back('{1'b1, 1'b1, 32'h44444444, 1'b0, 1'b1, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0});
    // Burst with 1..3 idle cycles between words.
    vecs.push_back('{1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 32'hA0000001, 1'b1, 1'b1, 1'b1});
    vecs.push_back('{1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 32'hA0000002, 1'b1, 1'b1, 1'b1});
    vecs.push_back('{1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 32'hA0000003, 1'b1, 1'b1, 1'b1});
    vecs.push_back('{1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 32'hA0000004, 1'b0, 1'b1, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0});

    // Reset state.
    #2;
    chk("reset_outputs",
        {31'd0, hrrdy, hspi_cts, fifo_write_en, busy, err_short, err_timeout, err_overrun},
        32'd0);
    chk("reset_data", fifo_write_data, 32'd0);
    chk("reset_burst_count", {16'd0, burst_count}, 32'd0);
    step();
    step();
    sys_rst_n = 1'b1;
    step();
    chk("cts_after_release", {31'd0, hspi_cts}, 32'd1);

    // Table: nominal and gapped bursts.
    for (int i = 0; i < vecs.size(); i++) begin
      hrreq = vecs[i].req;
      hrvld = vecs[i].vld;
      hrd   = vecs[i].d;
      if (vecs[i].e_wr) exp_q.push_back(vecs[i].d);
      step();
      chk($sformatf("v%0d_hrrdy", i), {31'd0, hrrdy}, {31'd0, vecs[i].e_rdy});
      chk($sformatf("v%0d_busy", i), {31'd0, busy}, {31'd0, vecs[i].e_busy});
      chk($sformatf("v%0d_wr_en", i), {31'd0, fifo_write_en}, {31'd0, vecs[i].e_wr});
      if (i == 5) chk("nominal_burst_count", {16'd0, burst_count}, 32'd1);
    end
    chk("gaps_burst_count", {16'd0, burst_count}, 32'd2);
    chk("gaps_no_errors", {29'd0, err_short, err_timeout, err_overrun}, 32'd0);

    // Short burst: hrreq drops after 2 words.
    w0 = writes;
    hrreq = 1'b1; hrvld = 1'b0;
    step();
    chk("short_hrrdy", {31'd0, hrrdy}, 32'd1);
    hrvld = 1'b1; hrd = 32'h55555555; exp_q.push_back(hrd);
    step();
    hrd = 32'h66666666; exp_q.push_back(hrd);
    step();
    hrreq = 1'b0; hrvld = 1'b0;
    step();
    chk("short_err", {31'd0, err_short}, 32'd1);
    chk("short_done_hrrdy_busy", {30'd0, hrrdy, busy}, 32'd1);
    step();
    chk("short_idle_busy", {31'd0, busy}, 32'd0);
    chk("short_burst_count", {16'd0, burst_count}, 32'd2);
    chk("short_writes", writes - w0, 32'd2);

    // Timeout: one word, then 8 idle cycles.
    w0 = writes;
    hrreq = 1'b1; hrvld = 1'b0;
    step();
    hrvld = 1'b1; hrd = 32'h77777777; exp_q.push_back(hrd);
    step();
    hrvld = 1'b0;
    for (int k = 0; k < 7; k++) step();
    chk("timeout_pre_hrrdy", {31'd0, hrrdy}, 32'd1);
    chk("timeout_pre_err", {31'd0, err_timeout}, 32'd0);
    step();
    chk("timeout_err", {31'd0, err_timeout}, 32'd1);
    chk("timeout_hrrdy", {31'd0, hrrdy}, 32'd0);
    hrreq = 1'b0;
    step();
    chk("timeout_writes", writes - w0, 32'd1);
    chk("timeout_burst_count", {16'd0, burst_count}, 32'd2);

    // Backpressure.
    fifo_almost_full = 1'b1; hrreq = 1'b1;
    for (int k = 0; k < 3; k++) step();
    chk("bp_hrrdy_cts", {30'd0, hrrdy, hspi_cts}, 32'd0);
    fifo_almost_full = 1'b0;
    step();
    step();
    chk("bp_release_hrrdy", {31'd0, hrrdy}, 32'd1);
    chk("bp_release_cts", {31'd0, hspi_cts}, 32'd1);

    // Reset mid-burst: the word presented with reset must never be written.
    w0 = writes;
    hrvld = 1'b1; hrd = 32'hDEADBEEF;
    sys_rst_n = 1'b0;
    #1;
    chk("rst_mid_outputs",
        {31'd0, hrrdy, hspi_cts, fifo_write_en, busy, err_short, err_timeout, err_overrun},
        32'd0);
    chk("rst_mid_burst_count", {16'd0, burst_count}, 32'd0);
    step();
    step();
    chk("rst_mid_writes", writes - w0, 32'd0);
    hrreq = 1'b0; hrvld = 1'b0; sys_rst_n = 1'b1;
    step();
    chk("rst_cts", {31'd0, hspi_cts}, 32'd1);

    // Overrun in IDLE.
    hrvld = 1'b1; hrd = 32'hBAD0BAD0;
    step();
    chk("overrun_err", {31'd0, err_overrun}, 32'd1);
    chk("overrun_no_write", {31'd0, fifo_write_en}, 32'd0);
    hrvld = 1'b0;
    step();
    chk("overrun_busy", {31'd0, busy}, 32'd0);

    #5;
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
